// File: rtl/riscv_fetch_q_if.sv
// Handshake bundle between the fetch queue, instruction memory and the
// decode stage. The master modport is the fetch unit; the slave modport is
// the surrounding environment (memory, pc_src logic and decode).
interface riscv_fetch_q_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/riscv_fetch_q.sv
// riscv_fetch_q: instruction-fetch front end. Issues sequential word fetches,
// tags each outstanding request with its pc, buffers in-order responses in a
// DEPTH-entry queue and hands {instr, instr_pc} to decode. A redirect flushes
// everything and discards the responses that are still outstanding.
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to
// the instr_* outputs in the same cycle when the queue is empty.
module riscv_fetch_q #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic            clk,
  input logic            rst,
  riscv_fetch_q_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t      q_mem   [DEPTH];
  logic [31:0] tag_mem [DEPTH];

  ptr_t        q_rd, q_wr, t_rd, t_wr;
  cnt_t        count, in_flight, drop_cnt;
  logic [31:0] fetch_pc;
  logic        wake;          // first cycle after reset: no request yet

  logic        accept, rsp_live, rsp_drop, rsp_keep;
  logic        pop, q_pop, q_push;
  cnt_t        occupancy;
  entry_t      head;

  // Request, response and pop qualification plus the decode-side outputs.
  // NOTE: every output of a combinational block gets a default at the top so
  // that no path through it leaves a signal unassigned and infers a latch.
  always_comb begin
    occupancy          = count + in_flight;
    head               = q_mem[q_rd];
    bus.imem_req_valid = rst && !wake && !bus.redirect && (occupancy < CW'(DEPTH));
    bus.imem_addr      = rst ? fetch_pc : RESET_PC;
    accept             = bus.imem_req_valid && bus.imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_live           = bus.imem_rsp_valid && (in_flight != '0);
    rsp_drop           = rsp_live && (drop_cnt != '0);
    rsp_keep           = rsp_live && (drop_cnt == '0) && !bus.redirect;
`ifdef FETCH_BYPASS_EN
    bus.instr_valid    = rst && ((count != '0) || rsp_keep);
    bus.instr          = (count != '0) ? head.word : bus.imem_rsp_data;
    bus.instr_pc       = (count != '0) ? head.pc   : tag_mem[t_rd];
`else
    bus.instr_valid    = rst && (count != '0);
    bus.instr          = head.word;
    bus.instr_pc       = head.pc;
`endif
    pop                = bus.instr_valid && bus.instr_ready && !bus.redirect;
    q_pop              = pop && (count != '0);
    // With an empty queue a pop can only be the forwarded response itself,
    // so that response is consumed instead of stored.
    q_push             = rsp_keep && !(pop && (count == '0));
  end

  // Control state: fetch pc, pointers, occupancy and discard bookkeeping.
  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc  <= RESET_PC;
      count     <= '0;
      in_flight <= '0;
      drop_cnt  <= '0;
      q_rd      <= '0;
      q_wr      <= '0;
      t_rd      <= '0;
      t_wr      <= '0;
      wake      <= 1'b1;
    end else begin
      wake <= 1'b0;
      if (bus.redirect) begin
        // Everything still outstanding after this cycle must be discarded.
        fetch_pc  <= bus.redirect_pc & ~32'h3;
        count     <= '0;
        q_rd      <= '0;
        q_wr      <= '0;
        t_rd      <= '0;
        t_wr      <= '0;
        in_flight <= in_flight - CW'(rsp_live);
        drop_cnt  <= in_flight - CW'(rsp_live);
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 32'd4;
          t_wr     <= t_wr + 1'b1;
        end
        if (rsp_keep) t_rd <= t_rd + 1'b1;
        if (q_push)   q_wr <= q_wr + 1'b1;
        if (q_pop)    q_rd <= q_rd + 1'b1;
        count     <= count + CW'(q_push) - CW'(q_pop);
        in_flight <= in_flight + CW'(accept) - CW'(rsp_live);
        if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // Storage writes for the pc tag FIFO and the instruction queue.
  // NOTE: the arrays carry no reset; pointers and count define which entries
  // are meaningful, so clearing the contents would only cost logic.
  always_ff @(posedge clk) begin
    if (accept) tag_mem[t_wr] <= fetch_pc;
    if (q_push) q_mem[q_wr]   <= '{pc: tag_mem[t_rd], word: bus.imem_rsp_data};
  end

  // Protocol and occupancy sanity checks for simulation.
  rsp_needs_req: assert property (@(posedge clk) disable iff (!rst)
    !(bus.imem_rsp_valid && (in_flight == '0)));
  occupancy_bound: assert property (@(posedge clk) disable iff (!rst)
    occupancy <= CW'(DEPTH));
endmodule
